ufloat_add_pipe: RTL

Parametrised, pipelined adder for unsigned mini-floats with an implicit leading one. It generalises the team's 7-bit equal-exponent adder to:
- arbitrary exponent difference;
- configurable exponent and mantissa widths;
- round-half-up;
- overflow detection with saturation;
- valid/ready flow control.

It sits between operand producers and the float datapath consumers, accepting one addition per cycle.

---
 rtl/ufloat_pkg.sv | 12 +
 rtl/ufloat_align_shift.sv | 11 +
 rtl/ufloat_add_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/ufloat_pkg.sv
// ufloat_pkg: shared widths and field layout for the unsigned mini-float adder
package ufloat_pkg;
  localparam int EW_DEF = 3;
  localparam int MW_DEF = 4;
  localparam int SIG_W = MW_DEF + 1;
  localparam int EXT_W = MW_DEF + 3;
  localparam int SUM_W = MW_DEF + 4;
  typedef struct packed {
    logic [EW_DEF-1:0] e;
    logic [MW_DEF-1:0] m;
  } ufloat_t;
endpackage

// File: rtl/ufloat_align_shift.sv
// ufloat_align_shift: right shifter whose result is zero once d reaches the width
module ufloat_align_shift #(
  parameter int W = 7,
  parameter int DW = 3
) (
  input  logic [W-1:0]  din,
  input  logic [DW-1:0] d,
  output logic [W-1:0]  dout
);
  assign dout = (int'(d) >= W) ? '0 : din >> d;
endmodule

// File: rtl/ufloat_add_pipe.sv
// ufloat_add_pipe: 3-stage valid/ready unsigned mini-float adder; UFADD_ROUND_EN selects round-half-up over truncation
module ufloat_add_pipe
  import ufloat_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW+MW-1:0] a,
  input  logic [EW+MW-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+MW-1:0] c,
  output logic            ovf
);
  localparam int GW = MW + SIG_W - MW_DEF;
  localparam int XW = GW + EXT_W - SIG_W;
  localparam int SW = XW + SUM_W - EXT_W;
  // lowest extension bit still needed: truncation never looks below the mantissa
`ifdef UFADD_ROUND_EN
  localparam int LB = 1;
`else
  localparam int LB = 2;
`endif
  logic adv, swap, carry;
  logic [EW-1:0] ea, eb, e_big, d;
  logic [MW-1:0] m_big, m_small, m_t, m_f;
  logic [XW-1:LB] sig_big, sig_small, sig_shift;
  logic [EW:0] e_n, e_f;
  logic s1_v, s2_v;
  logic [EW:0] s1_e, s2_e;
  logic [XW-1:LB] s1_big, s1_small;
  logic [SW-1:LB] s2_sum;
  logic [EW+MW-1:0] c_n;
  logic ovf_n;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign ea = a[EW+MW-1:MW];
  assign eb = b[EW+MW-1:MW];
  assign swap = ea < eb;
  assign e_big = swap ? eb : ea;
  assign d = swap ? eb - ea : ea - eb;
  assign m_big = swap ? b[MW-1:0] : a[MW-1:0];
  assign m_small = swap ? a[MW-1:0] : b[MW-1:0];
  assign sig_big = (XW-LB)'({1'b1, m_big, 2'b00} >> LB);
  assign sig_small = (XW-LB)'({1'b1, m_small, 2'b00} >> LB);
  ufloat_align_shift #(.W(XW-LB), .DW(EW)) u_shift (
    .din (sig_small),
    .d   (d),
    .dout(sig_shift)
  );
  assign carry = s2_sum[SW-1];
  assign e_n = s2_e + (EW+1)'(carry);
  assign m_t = carry ? s2_sum[MW+2:3] : s2_sum[MW+1:2];
`ifdef UFADD_ROUND_EN
  logic guard;
  logic [MW:0] m_r;
  assign guard = carry ? s2_sum[2] : s2_sum[1];
  assign m_r = {1'b0, m_t} + (MW+1)'(guard);
  assign e_f = e_n + (EW+1)'(m_r[MW]);
  assign m_f = m_r[MW-1:0];
`else
  assign e_f = e_n;
  assign m_f = m_t;
`endif
  assign ovf_n = e_f[EW];
  assign c_n = ovf_n ? '1 : {e_f[EW-1:0], m_f};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      s1_e <= '0;
      s1_big <= '0;
      s1_small <= '0;
      s2_e <= '0;
      s2_sum <= '0;
      c <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      s1_v <= in_valid;
      s1_e <= {1'b0, e_big};
      s1_big <= sig_big;
      s1_small <= sig_shift;
      s2_v <= s1_v;
      s2_e <= s1_e;
      s2_sum <= {1'b0, s1_big} + {1'b0, s1_small};
      out_valid <= s2_v;
      c <= c_n;
      ovf <= ovf_n;
    end
  end
endmodule
